// File: rtl/mod_74xx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_74xx_pkg
// Description : Shared definitions for the 74xx counter family: count
//               direction encodings and the terminal-value helper.
// Contents    : DIR_UP / DIR_DOWN - levels of the U_D direction pin
//               f_term_val()      - terminal (highest) count for a modulus
// Revision    : 1.0 - initial release
// ============================================================================
package mod_74xx_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Highest state of a modulus-N counter; an up count wraps from here to 0
    // and a down count wraps from 0 back to here.
    function automatic int unsigned f_term_val(input int unsigned modulus);
        return modulus - 1;
    endfunction

endpackage : mod_74xx_pkg
`default_nettype wire

// File: rtl/mod_74xx_next_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mod_74xx_next_cnt
// Description : Combinational next-count function for a modulus-N up/down
//               counter. The terminal flag drives both the wrap decision and
//               the ripple-carry output in the parent.
// Ports       : i_q        - current count
//               i_u_d      - direction (1 = up, 0 = down)
//               o_next     - count after one step in direction i_u_d
//               o_terminal - i_q is the terminal state for direction i_u_d
// Revision    : 1.0 - initial release
// ============================================================================
module mod_74xx_next_cnt
    import mod_74xx_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2**WIDTH
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_u_d,
    output logic [WIDTH-1:0] o_next,
    output logic             o_terminal
);

    localparam logic [WIDTH-1:0] c_TERM_VAL = WIDTH'(f_term_val(MODULUS));
    localparam logic [WIDTH-1:0] c_ZERO     = '0;
    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);

    always_comb begin
        o_next     = i_q;
        o_terminal = 1'b0;
        if (i_u_d == DIR_UP) begin
            o_terminal = (i_q == c_TERM_VAL);
            // A loaded value above the terminal value is never equal to it,
            // so it climbs to all-ones and wraps to 0 through the natural
            // binary overflow of the adder.
            o_next     = o_terminal ? c_ZERO : (i_q + c_ONE);
        end else begin
            o_terminal = (i_q == c_ZERO);
            o_next     = o_terminal ? c_TERM_VAL : (i_q - c_ONE);
        end
    end

endmodule : mod_74xx_next_cnt
`default_nettype wire

// File: rtl/mod_74x169_n.sv
`default_nettype none
// ============================================================================
// Module      : mod_74x169_n
// Description : Parametrised synchronous presettable binary up/down counter
//               with 74x169-style pins. Cascade stages by feeding RCO of one
//               stage into ENT of the next.
// Ports       : CLK    - clock, all state changes on the rising edge
//               CLR_N  - synchronous clear, active low (highest priority)
//               LOAD_N - synchronous parallel load of D, active low
//               ENP    - count enable P (does not affect RCO)
//               ENT    - count enable T (gates RCO, cascade input)
//               U_D    - direction, 1 = up, 0 = down
//               D      - parallel load data
//               Q      - registered count
//               RCO    - ripple carry out, combinational from Q/ENT/U_D
// Revision    : 1.0 - initial release
// ============================================================================
module mod_74x169_n #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2**WIDTH
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             LOAD_N,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             U_D,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;
    logic             w_terminal;

    mod_74xx_next_cnt #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next_cnt (
        .i_q        (r_q),
        .i_u_d      (U_D),
        .o_next     (w_next),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            r_q <= '0;
        end else if (!LOAD_N) begin
            r_q <= D;
        end else if (ENP && ENT) begin
            r_q <= w_next;
        end
    end

    assign Q   = r_q;
    // Not registered: a downstream stage must see the carry in the same
    // cycle so the whole chain steps on one edge.
    assign RCO = ENT & w_terminal;

endmodule : mod_74x169_n
`default_nettype wire
